// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq
//
// Iterative AES SubBytes sequencer. A 128-bit state is accepted over a
// valid/ready handshake. Its NB bytes are then fed one per clock through a
// single external S-box LUT. The substituted bytes are collected, and the
// finished state is presented over a second valid/ready handshake.
//
// Ports:
//   CLK        clock, all logic on the rising edge
//   RST        synchronous active-high reset
//   in_valid   input state valid
//   in_ready   block can accept a state (IDLE only)
//   in_state   input state, byte 0 in the top 8 bits (FIPS-197 order)
//   sbox_sel   registered S-box address
//   sbox_en    S-box enable, low only while RST is high
//   sbox_data  S-box output, a combinational function of sbox_sel
//   out_valid  substituted state valid (DONE only)
//   out_ready  downstream accepts out_state
//   out_state  substituted state, same byte order as in_state
//   busy       high while in RUN or DONE

module sub_bytes_seq #(
    parameter int NB = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*NB-1:0] in_state,
    output logic [7:0]      sbox_sel,
    output logic            sbox_en,
    input  logic [7:0]      sbox_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [8*NB-1:0] out_state,
    output logic            busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Byte k of a state sits at packed index NB-1-k, so indices are
    // mirrored through last_idx when addressing the byte arrays.
    localparam logic [3:0] LAST_IDX = 4'(NB - 1);

    logic [1:0]         state;
    logic [3:0]         idx;
    logic [NB-1:0][7:0] src;
    logic [NB-1:0][7:0] result;
    logic [NB-1:0][7:0] in_bytes;

    assign in_bytes = in_state;

    // The LUT must keep tracking sbox_sel even when the address does not
    // change between bytes, so the enable is simply "not in reset".
    assign sbox_en   = ~RST;

    // in_ready is masked by RST so that no handshake appears to complete
    // on an edge where reset actually wins.
    assign in_ready  = (state == IDLE) && !RST;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign out_state = result;

    // Main sequencer. In RUN, the byte captured on each edge is the LUT
    // response to the address registered on the previous edge. The address
    // for the next byte is loaded on that same edge. The result register
    // is written only on capture edges, so it holds the last block between
    // transfers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            idx      <= 4'd0;
            src      <= '0;
            result   <= '0;
            sbox_sel <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src      <= in_bytes;
                        idx      <= 4'd0;
                        sbox_sel <= in_bytes[NB-1];
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result[LAST_IDX - idx] <= sbox_data;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx      <= idx + 4'd1;
                        sbox_sel <= src[LAST_IDX - idx - 4'd1];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
